// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access controller slice.
package mem_access_pkg;

  localparam int ADDR_W_DEF   = 32'sd4;
  localparam int DATA_W_DEF   = 32'sd8;
  localparam int WAIT_CYC_DEF = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Command/result bundle between the read/write sequencer (master) and the
// memory access controller (slave).
interface mem_access_ctrl_if
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              exec;
  logic              rd_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              drop;
  logic              err;

  modport master (
    output exec, rd_wr, addr, wr_data,
    input  busy, done, rd_valid, rd_data, drop, err
  );

  modport slave (
    input  exec, rd_wr, addr, wr_data,
    output busy, done, rd_valid, rd_data, drop, err
  );

endinterface

// File: rtl/mem_access_ctrl_mem_array.sv
// Synchronous single-port word storage with registered read data.
// With PARITY_EN defined each word carries an even-parity bit checked on read.
module mem_array #(
  parameter int ADDR_W = 32'sd4,
  parameter int DATA_W = 32'sd8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              par_err
);

  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage is deliberately not reset so contents survive a controller reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

`ifdef PARITY_EN
  logic par_mem_r [DEPTH];
  logic rpar_r;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Parity bit written alongside its data word
  always_ff @(posedge clk) begin
    if (we) begin
      par_mem_r[addr] <= even_par(wdata);
    end
  end

  // Parity bit read in step with rdata_r
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpar_r <= 1'b0;
    end else begin
      rpar_r <= par_mem_r[addr];
    end
  end

  assign par_err = (even_par(rdata_r) != rpar_r);
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Executes one read or write per exec rising edge against a local array,
// with WAIT_CYC wait states. Optional PARITY_EN adds per-word parity checking.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mem_access_ctrl_if.slave bus
);

  localparam bit         HAS_WAIT_C = (WAIT_CYC > 32'sd0);
  localparam logic [3:0] CNT_LOAD_C = HAS_WAIT_C ? 4'(WAIT_CYC - 32'sd1) : 4'd0;

  state_e            state_r, state_n_s;
  logic [3:0]        cnt_r, cnt_n_s;
  logic              exec_q_r;
  logic              start_s;
  logic              capture_s;
  logic              mem_we_s;
  logic              rw_q_r;
  logic [ADDR_W-1:0] addr_q_r;
  logic [DATA_W-1:0] wd_q_r;
  logic [DATA_W-1:0] mem_rdata_s;
  logic              par_err_s;

  logic              busy_r, done_r, rd_valid_r, drop_r, err_r;
  logic [DATA_W-1:0] rd_data_r;

  assign start_s = bus.exec & ~exec_q_r;

  // Edge-detect history and command capture on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_q_r <= 1'b0;
      rw_q_r   <= RW_READ;
      addr_q_r <= {ADDR_W{1'b0}};
      wd_q_r   <= {DATA_W{1'b0}};
    end else begin
      exec_q_r <= bus.exec;
      if (capture_s) begin
        rw_q_r   <= bus.rd_wr;
        addr_q_r <= bus.addr;
        wd_q_r   <= bus.wr_data;
      end
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Next-state, wait countdown and memory write enable
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    capture_s = 1'b0;
    mem_we_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          capture_s = 1'b1;
          state_n_s = ST_SETUP;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (HAS_WAIT_C) begin
          state_n_s = ST_WAIT;
          cnt_n_s   = CNT_LOAD_C;
        end else begin
          state_n_s = ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_n_s = ST_ACCESS;
        end else begin
          cnt_n_s = cnt_r - 4'd1;
        end
      end
      ST_ACCESS: begin
        mem_we_s  = (rw_q_r == RW_WRITE);
        state_n_s = ST_DONE;
      end
      ST_DONE: begin
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // The array address is stable from SETUP on, so its registered read data
  // already holds mem[addr_q] while in ACCESS.
  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (mem_we_s),
    .addr    (addr_q_r),
    .wdata   (wd_q_r),
    .rdata   (mem_rdata_s),
    .par_err (par_err_s)
  );

  // Registered status outputs, derived from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      drop_r     <= 1'b0;
      err_r      <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      busy_r     <= (state_n_s != ST_IDLE);
      done_r     <= (state_n_s == ST_DONE);
      rd_valid_r <= (state_n_s == ST_DONE) && (rw_q_r == RW_READ);
      drop_r     <= start_s && (state_r != ST_IDLE);
      err_r      <= (state_r == ST_ACCESS) && (rw_q_r == RW_READ) && par_err_s;
      if ((state_r == ST_ACCESS) && (rw_q_r == RW_READ)) begin
        rd_data_r <= mem_rdata_s;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.drop     = drop_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (ADDR_W=4, DATA_W=8, WAIT_CYC=2).
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mem_access_ctrl #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .WAIT_CYC (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle exec rises; c counts cycles after that.
  task automatic run_cmd(input logic rw, input logic [3:0] a, input logic [7:0] d,
                         input int drop_at, input int hold, input int ncyc,
                         output int done_cyc, output int n_done, output int n_drop,
                         output int drop_cyc, output logic busy1,
                         output logic rv_at_done, output logic err_at_done);
    done_cyc = -1; n_done = 0; n_drop = 0; drop_cyc = -1;
    busy1 = 1'b0; rv_at_done = 1'b0; err_at_done = 1'b0;
    bus.rd_wr = rw; bus.addr = a; bus.wr_data = d; bus.exec = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick;
      if (c == hold) bus.exec = 1'b0;
      if (drop_at > 0 && c == drop_at) bus.exec = 1'b1;
      if (drop_at > 0 && c == drop_at + 1) bus.exec = 1'b0;
      if (c == 1) busy1 = bus.busy;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc    = c;
          rv_at_done  = bus.rd_valid;
          err_at_done = bus.err;
        end
      end
      if (bus.drop === 1'b1) begin
        n_drop++;
        if (drop_cyc < 0) drop_cyc = c;
      end
    end
    bus.exec = 1'b0;
  endtask

  int   dc, nd, ndr, drc;
  logic b1, rv, er;

  initial begin
    reset = 1'b1;
    bus.exec = 1'b0; bus.rd_wr = 1'b0; bus.addr = 4'd0; bus.wr_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_rd_valid", bus.rd_valid, 1'b0);
    check_eq("rst_drop", bus.drop, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    check_eq("rst_rd_data", bus.rd_data, 8'h00);
    check_eq("rst_state", 32'(u_dut.state_r), 32'(ST_IDLE));
    reset = 1'b0;
    tick;

    // 1: write A5 to addr 3
    run_cmd(RW_WRITE, 4'd3, 8'hA5, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t1_busy_c1", b1, 1'b1);
    check_eq("t1_done_cyc", dc, 32'd5);
    check_eq("t1_n_done", nd, 32'd1);
    check_eq("t1_rd_valid", rv, 1'b0);
    check_eq("t1_err", er, 1'b0);
    check_eq("t1_no_drop", ndr, 32'd0);
    check_eq("t1_busy_c6", bus.busy, 1'b0);

    // 2: read addr 3, issued back-to-back in the first IDLE cycle
    run_cmd(RW_READ, 4'd3, 8'h00, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t2_done_cyc", dc, 32'd5);
    check_eq("t2_rd_valid", rv, 1'b1);
    check_eq("t2_err", er, 1'b0);
    check_eq("t2_rd_data", bus.rd_data, 8'hA5);
    repeat (3) tick;
    check_eq("t2_rd_data_held", bus.rd_data, 8'hA5);

    // 3: second edge two cycles in is dropped; write still lands on time
    run_cmd(RW_WRITE, 4'd5, 8'h3C, 2, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t3_n_drop", ndr, 32'd1);
    check_eq("t3_drop_cyc", drc, 32'd3);
    check_eq("t3_done_cyc", dc, 32'd5);
    check_eq("t3_n_done", nd, 32'd1);
    check_eq("t3_rd_data_unchanged", bus.rd_data, 8'hA5);
    run_cmd(RW_READ, 4'd5, 8'h00, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t3_readback", bus.rd_data, 8'h3C);

    // 4: exec held high for 20 cycles -> a single access
    run_cmd(RW_READ, 4'd3, 8'h00, 0, 20, 24, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t4_n_done", nd, 32'd1);
    check_eq("t4_done_cyc", dc, 32'd5);
    check_eq("t4_n_drop", ndr, 32'd0);
    check_eq("t4_rd_data", bus.rd_data, 8'hA5);

    // 5: reset during WAIT of a write to addr 3
    run_cmd(RW_WRITE, 4'd7, 8'h42, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    bus.rd_wr = RW_WRITE; bus.addr = 4'd3; bus.wr_data = 8'h11; bus.exec = 1'b1;
    tick;
    bus.exec = 1'b0;
    tick;
    check_eq("t5_busy_pre", bus.busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_busy", bus.busy, 1'b0);
    check_eq("t5_done", bus.done, 1'b0);
    check_eq("t5_rd_valid", bus.rd_valid, 1'b0);
    check_eq("t5_rd_data", bus.rd_data, 8'h00);
    check_eq("t5_state", 32'(u_dut.state_r), 32'(ST_IDLE));
    tick;
    check_eq("t5_done_in_rst", bus.done, 1'b0);
    // exec already high in the first cycle after reset counts as an edge
    bus.rd_wr = RW_READ; bus.addr = 4'd7; bus.exec = 1'b1;
    tick;
    reset = 1'b0;
    run_cmd(RW_READ, 4'd7, 8'h00, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t5_post_done_cyc", dc, 32'd5);
    check_eq("t5_post_rd_data", bus.rd_data, 8'h42);
    run_cmd(RW_READ, 4'd3, 8'h00, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t5_aborted_target", bus.rd_data, 8'hA5);

`ifdef PARITY_EN
    // 6: corrupt stored parity of addr 1 and read it back
    run_cmd(RW_WRITE, 4'd1, 8'h0F, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    u_dut.u_mem.par_mem_r[1] = ~u_dut.u_mem.par_mem_r[1];
    run_cmd(RW_READ, 4'd1, 8'h00, 0, 1, 6, dc, nd, ndr, drc, b1, rv, er);
    check_eq("t6_done_cyc", dc, 32'd5);
    check_eq("t6_err", er, 1'b1);
    check_eq("t6_rd_data", bus.rd_data, 8'h0F);
    check_eq("t6_err_one_cycle", bus.err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
